ex_mem_lsu: RTL and testbench

EX→MEM pipeline stage of the in-order RISC-V core: it registers the execute-stage result and runs the data-RAM load/store transaction, then presents the aligned write-back value to WB. It drives an SRAM-like split address/data handshake and holds the pipe through `allow_in_mem` until the access completes. Cancel (trap/redirect) kills the stage's instruction, and a response that is already in flight is drained and discarded.

---
 rtl/ex_mem_lsu_if.sv | 22 ++
 rtl/ex_mem_lsu.sv | 178 +++++++++++++++++
 tb/tb_ex_mem_lsu.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_lsu_if.sv
// Data-RAM bus between the EX->MEM load/store unit (master) and the data SRAM (slave).
// Split handshake: the request phase ends with addr_ok and the response phase ends with data_ok.
interface ex_mem_lsu_if;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [3:0]  ram_wstrb;
   logic [31:0] ram_wdata;
   logic        ram_addr_ok;
   logic        ram_data_ok;
   logic [31:0] ram_rdata;

   modport master (
      output ram_req, ram_we, ram_addr, ram_wstrb, ram_wdata,
      input  ram_addr_ok, ram_data_ok, ram_rdata
   );

   modport slave (
      input  ram_req, ram_we, ram_addr, ram_wstrb, ram_wdata,
      output ram_addr_ok, ram_data_ok, ram_rdata
   );
endinterface

// File: rtl/ex_mem_lsu.sv
// EX->MEM pipeline stage: registers the EX result, runs the data-RAM access and presents aligned WB data.
// Optional macro MISALIGN_EXC_EN: misaligned half/word accesses skip the bus and flag misalign_mem.
//
// state     | meaning
// IDLE      | stage empty
// REQ       | request on the bus, waiting for addr_ok
// WAIT      | request accepted, waiting for data_ok
// DONE      | result final, waiting for WB to accept
// DISCARD   | instruction cancelled, draining the in-flight response
module ex_mem_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cancel,
   input  logic        valid_ex,
   output logic        allow_in_mem,
   input  logic [31:0] alu_result_ex,
   input  logic [31:0] rs2_data_ex,
   input  logic [4:0]  rd_ex,
   input  logic [31:0] pc_ex,
   input  logic [3:0]  control_flow_ex,
   input  logic [2:0]  funct3_ex,
   ex_mem_lsu_if.master ram,
   input  logic        allow_in_wb,
   output logic        valid_mem,
   output logic        ready_go_mem,
   output logic [4:0]  rd_mem,
   output logic [31:0] pc_mem,
   output logic        write_reg_mem,
   output logic [31:0] wb_data_mem,
   output logic        misalign_mem
);
   localparam int DATA_WIDTH = 32;
   localparam int RD_WIDTH   = 5;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_REQ     = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_DISCARD = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d, sdata_q, sdata_d, pc_q, pc_d, wb_q, wb_d;
   logic [RD_WIDTH-1:0]   rd_q, rd_d;
   logic [3:0]            ctrl_q, ctrl_d;   // {mem_read, mem_write, mem2reg, write_reg}
   logic [2:0]            f3_q, f3_d;
   logic                  mis_q, mis_d;

   logic                  capture, cap_mem, mis_cap;
   logic [2:0]            cap_state;
   logic [4:0]            shamt;
   logic [DATA_WIDTH-1:0] shifted, load_val, st_wdata;
   logic [3:0]            st_strb;

   assign valid_mem    = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DONE);
   assign ready_go_mem = (state_q == S_DONE);
   assign allow_in_mem = (state_q != S_DISCARD) && (!valid_mem || (ready_go_mem && allow_in_wb));
   assign capture      = valid_ex && allow_in_mem && !cancel;
   assign cap_mem      = control_flow_ex[3] | control_flow_ex[2];

`ifdef MISALIGN_EXC_EN
   assign mis_cap = cap_mem && (((funct3_ex[1:0] == 2'b01) && alu_result_ex[0]) ||
                                ((funct3_ex[1:0] == 2'b10) && (alu_result_ex[1:0] != 2'b00)));
`else
   assign mis_cap = 1'b0;
`endif

   assign cap_state = (cap_mem && !mis_cap) ? S_REQ : S_DONE;

   // Without the misalign check, half accesses use addr[1] only and word accesses ignore addr[1:0].
   always_comb begin
      shamt    = 5'd0;
      st_strb  = 4'b1111;
      st_wdata = sdata_q;
      case (f3_q[1:0])
         2'b00: begin
            shamt    = {addr_q[1:0], 3'b000};
            st_strb  = 4'b0001 << addr_q[1:0];
            st_wdata = {4{sdata_q[7:0]}};
         end
         2'b01: begin
            shamt    = {addr_q[1], 4'b0000};
            st_strb  = 4'b0011 << {addr_q[1], 1'b0};
            st_wdata = {2{sdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      shifted = ram.ram_rdata >> shamt;
      case (f3_q)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {24'd0, shifted[7:0]};
         3'b101:  load_val = {16'd0, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   assign ram.ram_req   = (state_q == S_REQ);
   assign ram.ram_we    = ram.ram_req & ctrl_q[2];
   assign ram.ram_addr  = {addr_q[31:2], 2'b00};
   assign ram.ram_wstrb = ram.ram_we ? st_strb : 4'b0000;
   assign ram.ram_wdata = st_wdata;

   assign rd_mem        = rd_q;
   assign pc_mem        = pc_q;
   assign wb_data_mem   = wb_q;
   assign misalign_mem  = mis_q & valid_mem;
   assign write_reg_mem = ctrl_q[0] & valid_mem & !misalign_mem;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sdata_d = sdata_q;
      pc_d    = pc_q;
      wb_d    = wb_q;
      rd_d    = rd_q;
      ctrl_d  = ctrl_q;
      f3_d    = f3_q;
      mis_d   = mis_q;
      if (capture) begin
         addr_d  = alu_result_ex;
         sdata_d = rs2_data_ex;
         pc_d    = pc_ex;
         wb_d    = alu_result_ex;
         rd_d    = rd_ex;
         ctrl_d  = control_flow_ex;
         f3_d    = funct3_ex;
         mis_d   = mis_cap;
      end
      case (state_q)
         S_IDLE: if (capture) state_d = cap_state;
         S_REQ: begin
            if (cancel)                 state_d = ram.ram_addr_ok ? S_DISCARD : S_IDLE;
            else if (ram.ram_addr_ok)   state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ram.ram_data_ok) begin
               state_d = cancel ? S_IDLE : S_DONE;
               if (ctrl_q[1]) wb_d = load_val;
            end else if (cancel) begin
               state_d = S_DISCARD;
            end
         end
         S_DONE: begin
            if (cancel)           state_d = S_IDLE;
            else if (allow_in_wb) state_d = capture ? cap_state : S_IDLE;
         end
         S_DISCARD: if (ram.ram_data_ok) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         sdata_q <= '0;
         pc_q    <= '0;
         wb_q    <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
         f3_q    <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sdata_q <= sdata_d;
         pc_q    <= pc_d;
         wb_q    <= wb_d;
         rd_q    <= rd_d;
         ctrl_q  <= ctrl_d;
         f3_q    <= f3_d;
         mis_q   <= mis_d;
      end
   end
endmodule

// File: tb/tb_ex_mem_lsu.sv
// Scoreboard bench for ex_mem_lsu: expected bus requests and WB results are queued at issue time
// and popped when the DUT hands them over; a small RAM responder provides programmable delays.
module tb_ex_mem_lsu;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, cancel, valid_ex, allow_in_mem, allow_in_wb;
   logic [31:0] alu_result_ex, rs2_data_ex, pc_ex;
   logic [4:0]  rd_ex;
   logic [3:0]  control_flow_ex;
   logic [2:0]  funct3_ex;
   logic        valid_mem, ready_go_mem, write_reg_mem, misalign_mem;
   logic [4:0]  rd_mem;
   logic [31:0] pc_mem, wb_data_mem;

   ex_mem_lsu_if bus();

   ex_mem_lsu dut (
      .clk(clk), .rst_n(rst_n), .cancel(cancel), .valid_ex(valid_ex), .allow_in_mem(allow_in_mem),
      .alu_result_ex(alu_result_ex), .rs2_data_ex(rs2_data_ex), .rd_ex(rd_ex), .pc_ex(pc_ex),
      .control_flow_ex(control_flow_ex), .funct3_ex(funct3_ex), .ram(bus), .allow_in_wb(allow_in_wb),
      .valid_mem(valid_mem), .ready_go_mem(ready_go_mem), .rd_mem(rd_mem), .pc_mem(pc_mem),
      .write_reg_mem(write_reg_mem), .wb_data_mem(wb_data_mem), .misalign_mem(misalign_mem)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   typedef struct { logic [31:0] wb; bit cw; logic [4:0] rd; logic [31:0] pc; logic wr; logic mis; } wb_exp_t;
   typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata; } bus_exp_t;
   wb_exp_t  wb_q[$];
   bus_exp_t bus_q[$];

   task automatic exp_wb(input logic [31:0] wb, input bit cw, input logic [4:0] rd, input logic [31:0] pc,
                         input logic wr, input logic mis);
      wb_exp_t e;
      e.wb = wb; e.cw = cw; e.rd = rd; e.pc = pc; e.wr = wr; e.mis = mis;
      wb_q.push_back(e);
   endtask

   task automatic exp_bus(input logic [31:0] addr, input logic we, input logic [3:0] strb, input logic [31:0] wdata);
      bus_exp_t e;
      e.addr = addr; e.we = we; e.strb = strb; e.wdata = wdata;
      bus_q.push_back(e);
   endtask

   // RAM responder, acts 2 time units after each rising edge
   int addr_dly = 0, data_dly = 0, acnt = 0, dcnt = 0;
   bit pend = 0;
   logic [31:0] rd_word = '0;

   task automatic set_ram(input int a, input int d);
      addr_dly = a; data_dly = d; acnt = a; pend = 0;
   endtask

   initial begin
      bus.ram_addr_ok = 1'b0; bus.ram_data_ok = 1'b0; bus.ram_rdata = '0;
      forever begin
         @(posedge clk); #2;
         bus.ram_addr_ok = 1'b0; bus.ram_data_ok = 1'b0; bus.ram_rdata = '0;
         if (pend) begin
            if (dcnt == 0) begin bus.ram_data_ok = 1'b1; bus.ram_rdata = rd_word; pend = 0; end
            else dcnt--;
         end else if (bus.ram_req) begin
            if (acnt == 0) begin bus.ram_addr_ok = 1'b1; pend = 1; dcnt = data_dly; acnt = addr_dly; end
            else acnt--;
         end
      end
   end

   // Monitor: bus handshakes and WB hand-overs against the scoreboard
   initial begin
      wb_exp_t  we_e;
      bus_exp_t be;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.ram_req && bus.ram_addr_ok) begin
               chk_val("bus_expected", 32'(bus_q.size() != 0), 1);
               if (bus_q.size() != 0) begin
                  be = bus_q.pop_front();
                  chk_val("ram_addr", bus.ram_addr, be.addr);
                  chk_val("ram_we", bus.ram_we, be.we);
                  chk_val("ram_wstrb", bus.ram_wstrb, be.strb);
                  if (be.we) chk_val("ram_wdata", bus.ram_wdata, be.wdata);
               end
            end
            if (valid_mem && ready_go_mem && allow_in_wb) begin
               chk_val("wb_expected", 32'(wb_q.size() != 0), 1);
               if (wb_q.size() != 0) begin
                  we_e = wb_q.pop_front();
                  if (we_e.cw) chk_val("wb_data", wb_data_mem, we_e.wb);
                  chk_val("rd_mem", rd_mem, we_e.rd);
                  chk_val("pc_mem", pc_mem, we_e.pc);
                  chk_val("write_reg", write_reg_mem, we_e.wr);
                  chk_val("misalign", misalign_mem, we_e.mis);
               end
            end
         end
      end
   end

   task automatic issue(input logic [3:0] ctrl, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
      bit ok = 0;
      control_flow_ex = ctrl; funct3_ex = f3; alu_result_ex = addr; rs2_data_ex = rs2;
      rd_ex = rd; pc_ex = pc; valid_ex = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (allow_in_mem) begin ok = 1; break; end
      end
      chk_val("issue_accept", 32'(ok), 1);
      @(posedge clk); #1;
      valid_ex = 1'b0;
   endtask

   task automatic wait_rdy(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         n = i;
         if (ready_go_mem) break;
      end
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!valid_mem && allow_in_mem && wb_q.size() == 0) begin ok = 1; break; end
      end
      chk_val("drain", 32'(ok), 1);
      @(posedge clk); #1;
   endtask

   localparam logic [3:0] C_ALU = 4'b0001, C_LD = 4'b1011, C_ST = 4'b0100;

   initial begin
      int n, stall, reqc;
      logic [31:0] held;
      rst_n = 1'b0; cancel = 1'b0; valid_ex = 1'b0; allow_in_wb = 1'b1;
      alu_result_ex = '0; rs2_data_ex = '0; pc_ex = '0; rd_ex = '0; control_flow_ex = '0; funct3_ex = '0;
      repeat (2) @(negedge clk);
      chk_val("rst_valid", valid_mem, 0);
      chk_val("rst_allow", allow_in_mem, 1);
      chk_val("rst_req", bus.ram_req, 0);
      chk_val("rst_ready", ready_go_mem, 0);
      chk_val("rst_wb", wb_data_mem, 0);
      chk_val("rst_wr", write_reg_mem, 0);
      chk_val("rst_mis", misalign_mem, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_ram(0, 0);

      exp_wb(32'h12345678, 1, 5'd3, 32'h1000, 1, 0);
      issue(C_ALU, 3'b000, 32'h12345678, 32'h0, 5'd3, 32'h1000);
      wait_rdy(n); chk_val("alu_latency", n, 1);
      drain();

      rd_word = 32'hDEADBEEF;
      exp_bus(32'h100, 0, 4'b0000, 0);
      exp_wb(32'hDEADBEEF, 1, 5'd5, 32'h1004, 1, 0);
      issue(C_LD, 3'b010, 32'h100, 32'h0, 5'd5, 32'h1004);
      wait_rdy(n); chk_val("lw_latency", n, 3);
      drain();

      rd_word = 32'h80112233;
      exp_bus(32'h100, 0, 4'b0000, 0);
      exp_wb(32'hFFFFFF80, 1, 5'd6, 32'h1008, 1, 0);
      issue(C_LD, 3'b000, 32'h103, 32'h0, 5'd6, 32'h1008);
      drain();
      exp_bus(32'h100, 0, 4'b0000, 0);
      exp_wb(32'h00000080, 1, 5'd7, 32'h100C, 1, 0);
      issue(C_LD, 3'b100, 32'h103, 32'h0, 5'd7, 32'h100C);
      drain();

      exp_bus(32'h100, 1, 4'b1100, 32'hABCDABCD);
      exp_wb(0, 0, 5'd0, 32'h1010, 0, 0);
      issue(C_ST, 3'b001, 32'h102, 32'h0000ABCD, 5'd0, 32'h1010);
      drain();
      set_ram(1, 1);
      exp_bus(32'h100, 1, 4'b0010, 32'hEFEFEFEF);
      exp_wb(0, 0, 5'd0, 32'h1014, 0, 0);
      issue(C_ST, 3'b000, 32'h101, 32'h123456EF, 5'd0, 32'h1014);
      drain();
      exp_bus(32'h104, 1, 4'b1111, 32'hCAFEF00D);
      exp_wb(0, 0, 5'd0, 32'h1018, 0, 0);
      issue(C_ST, 3'b010, 32'h104, 32'hCAFEF00D, 5'd0, 32'h1018);
      drain();

      // LH with addr_ok delayed 2 cycles, then WB stalled 3 cycles
      set_ram(2, 0);
      rd_word = 32'h80011234;
      allow_in_wb = 1'b0;
      exp_bus(32'h100, 0, 4'b0000, 0);
      exp_wb(32'hFFFF8001, 1, 5'd9, 32'h101C, 1, 0);
      issue(C_LD, 3'b001, 32'h102, 32'h0, 5'd9, 32'h101C);
      stall = 0; reqc = 0; held = '0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!valid_mem) break;
         if (bus.ram_req) begin reqc++; chk_val("req_addr_hold", bus.ram_addr, 32'h100); end
         if (!(ready_go_mem && allow_in_wb)) chk_val("stall_allow", allow_in_mem, 0);
         if (ready_go_mem) begin
            if (stall == 0) held = wb_data_mem;
            else chk_val("wb_stable", wb_data_mem, held);
            stall++;
         end
         @(posedge clk); #1;
         if (stall == 3) allow_in_wb = 1'b1;
      end
      allow_in_wb = 1'b1;
      chk_val("req_cycles", reqc, 3);
      chk_val("stall_cycles", stall, 4);
      drain();

      set_ram(0, 3);
      exp_bus(32'h100, 0, 4'b0000, 0);
      exp_wb(32'h00001234, 1, 5'd10, 32'h1020, 1, 0);
      issue(C_LD, 3'b101, 32'h100, 32'h0, 5'd10, 32'h1020);
      drain();

      set_ram(0, 0);
      rd_word = 32'h01020304;
`ifdef MISALIGN_EXC_EN
      exp_wb(0, 0, 5'd11, 32'h1024, 0, 1);
      issue(C_LD, 3'b010, 32'h102, 32'h0, 5'd11, 32'h1024);
      @(negedge clk);
      chk_val("mis_no_req", bus.ram_req, 0);
      chk_val("mis_ready", ready_go_mem, 1);
      chk_val("mis_flag", misalign_mem, 1);
      chk_val("mis_no_wr", write_reg_mem, 0);
`else
      exp_bus(32'h100, 0, 4'b0000, 0);
      exp_wb(32'h01020304, 1, 5'd11, 32'h1024, 1, 0);
      issue(C_LD, 3'b010, 32'h102, 32'h0, 5'd11, 32'h1024);
`endif
      drain();

      // cancel in REQ before addr_ok: no handshake may happen
      set_ram(3, 0);
      issue(C_LD, 3'b010, 32'h300, 32'h0, 5'd12, 32'h1028);
      cancel = 1'b1;
      @(negedge clk); chk_val("creq_req", bus.ram_req, 1);
      @(posedge clk); #1; cancel = 1'b0;
      @(negedge clk);
      chk_val("creq_req_off", bus.ram_req, 0);
      chk_val("creq_valid", valid_mem, 0);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;

      // cancel in WAIT, response arrives two cycles later
      set_ram(0, 2);
      exp_bus(32'h200, 0, 4'b0000, 0);
      issue(C_LD, 3'b010, 32'h200, 32'h0, 5'd13, 32'h102C);
      @(posedge clk); #1; cancel = 1'b1;
      @(posedge clk); #1; cancel = 1'b0;
      @(negedge clk);
      chk_val("disc_valid", valid_mem, 0);
      chk_val("disc_allow", allow_in_mem, 0);
      chk_val("disc_wr", write_reg_mem, 0);
      @(negedge clk);
      chk_val("disc_allow2", allow_in_mem, 0);
      @(negedge clk);
      chk_val("disc_end_allow", allow_in_mem, 1);
      @(posedge clk); #1;

      // cancel in DONE
      set_ram(0, 0);
      allow_in_wb = 1'b0;
      issue(C_ALU, 3'b000, 32'h55, 32'h0, 5'd14, 32'h1030);
      cancel = 1'b1;
      @(negedge clk); chk_val("cdone_ready", ready_go_mem, 1);
      @(posedge clk); #1; cancel = 1'b0; allow_in_wb = 1'b1;
      @(negedge clk);
      chk_val("cdone_valid", valid_mem, 0);
      @(posedge clk); #1;

      // reset in the middle of a request
      set_ram(5, 0);
      issue(C_LD, 3'b010, 32'h400, 32'h0, 5'd15, 32'h1034);
      @(negedge clk);
      chk_val("rmid_req_before", bus.ram_req, 1);
      #1 rst_n = 1'b0;
      #1;
      chk_val("rmid_req", bus.ram_req, 0);
      chk_val("rmid_valid", valid_mem, 0);
      chk_val("rmid_allow", allow_in_mem, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_ram(0, 0);

      exp_wb(32'hA5A50001, 1, 5'd1, 32'h2000, 1, 0);
      issue(C_ALU, 3'b000, 32'hA5A50001, 32'h0, 5'd1, 32'h2000);
      drain();

      chk_val("wb_q_left", wb_q.size(), 0);
      chk_val("bus_q_left", bus_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
